// File: rtl/fp_result_drain.sv
// Drains filter-pipeline result vectors: captures one lane per cycle into a 2-entry FIFO and emits set-bit IDs lowest first.
// Optional feature macro: FP_DRAIN_DROP_CNT_EN builds a saturating dropped-vector counter on drop_cnt.
module fp_result_drain #(
  parameter int INPUTS           = 4,
  parameter int BIT_VEC_SIZE     = 128,
  parameter int BIT_VEC_SIZE_LOG = 7,
  localparam int SEL_W           = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [BIT_VEC_SIZE-1:0]     in [INPUTS],
  input  logic                        valid_in [INPUTS],
  input  logic [SEL_W-1:0]            lane_sel,
  output logic [BIT_VEC_SIZE_LOG-1:0] id_out,
  output logic                        id_valid,
  input  logic                        id_ready,
  output logic                        id_last,
  output logic                        id_none,
  output logic                        full,
  output logic [15:0]                 drop_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, SCAN} state_t;

  state_t                      state, state_next;
  logic [BIT_VEC_SIZE-1:0]     fifo_mem [2];
  logic                        wr_ptr, rd_ptr;
  logic [1:0]                  count, count_next;
  logic [BIT_VEC_SIZE-1:0]     scan_reg;
  logic [BIT_VEC_SIZE-1:0]     scan_rest;
  logic [BIT_VEC_SIZE_LOG-1:0] low_idx;
  logic [BIT_VEC_SIZE-1:0]     sel_vec;
  logic                        sel_valid;
  logic                        scan_last;
  logic                        beat_accept;
  logic                        retire;
  logic                        push_req;
  logic                        push_ok;
  logic                        fifo_full;

  always_comb begin
    sel_vec   = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < INPUTS; i++) begin
      if (lane_sel == SEL_W'(i)) begin
        sel_vec   = in[i];
        sel_valid = valid_in[i];
      end
    end
  end

  // Lowest set bit wins; an all-zero register yields index 0.
  always_comb begin
    low_idx = '0;
    for (int i = BIT_VEC_SIZE - 1; i >= 0; i--) begin
      if (scan_reg[i]) low_idx = BIT_VEC_SIZE_LOG'(i);
    end
  end

  assign scan_rest = scan_reg & (scan_reg - BIT_VEC_SIZE'(1));
  assign scan_last = (scan_rest == '0);

  assign id_valid  = (state == SCAN) && !rst;
  assign id_out    = id_valid ? low_idx : '0;
  assign id_last   = id_valid && scan_last;
  assign id_none   = id_valid && (scan_reg == '0);

  // The vector being scanned keeps its FIFO slot until its last beat retires it,
  // so a push in the retiring cycle reuses that slot instead of being dropped.
  assign beat_accept = id_valid && id_ready;
  assign retire      = beat_accept && scan_last;
  assign fifo_full   = (count == 2'd2);
  assign full        = fifo_full && !rst;
  assign push_req    = sel_valid && !rst;
  assign push_ok     = push_req && (!fifo_full || retire);

  always_comb begin
    count_next = count;
    case ({push_ok, retire})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (count != 2'd0) state_next = LOAD;
      LOAD: state_next = SCAN;
      SCAN: if (retire) state_next = (count_next != 2'd0) ? LOAD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      scan_reg <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (retire)  rd_ptr <= ~rd_ptr;
      if (state == LOAD)    scan_reg <= fifo_mem[rd_ptr];
      else if (beat_accept) scan_reg <= scan_rest;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= sel_vec;
  end

`ifdef FP_DRAIN_DROP_CNT_EN
  logic        drop;
  logic [15:0] drop_q;

  assign drop = push_req && !push_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
    end else if (drop && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_cnt = rst ? 16'd0 : drop_q;
`else
  assign drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fp_result_drain.sv
// Directed bench for fp_result_drain: inputs change 1ns after the rising edge and outputs are checked there.
module tb_fp_result_drain;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] in_vec [4];
  logic         valid_in [4];
  logic [1:0]   lane_sel;
  logic [6:0]   id_out;
  logic         id_valid;
  logic         id_ready;
  logic         id_last;
  logic         id_none;
  logic         full;
  logic [15:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

`ifdef FP_DRAIN_DROP_CNT_EN
  localparam int EXP_DROP = 2;
`else
  localparam int EXP_DROP = 0;
`endif

  fp_result_drain dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in_vec),
    .valid_in (valid_in),
    .lane_sel (lane_sel),
    .id_out   (id_out),
    .id_valid (id_valid),
    .id_ready (id_ready),
    .id_last  (id_last),
    .id_none  (id_none),
    .full     (full),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic checkBeat(input string tag, input int id, input bit last, input bit none);
    checkOutput({tag, "_valid"}, 32'(id_valid), 32'd1);
    checkOutput({tag, "_id"},    32'(id_out),   32'(id));
    checkOutput({tag, "_last"},  32'(id_last),  32'(last));
    checkOutput({tag, "_none"},  32'(id_none),  32'(none));
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_valid"}, 32'(id_valid), 32'd0);
  endtask

  // Presents vec on one lane for exactly one capture edge.
  task automatic applyStimulus(input int lane, input logic [127:0] vec);
    lane_sel       = 2'(lane);
    in_vec[lane]   = vec;
    valid_in[lane] = 1'b1;
    tick();
    valid_in[lane] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time exceeded");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] v;

    rst      = 1'b1;
    id_ready = 1'b0;
    lane_sel = '0;
    for (int i = 0; i < 4; i++) begin
      in_vec[i]   = '0;
      valid_in[i] = 1'b0;
    end
    tick();
    tick();
    $display("[TB] reset state");
    checkOutput("rst_valid", 32'(id_valid), 32'd0);
    checkOutput("rst_id",    32'(id_out),   32'd0);
    checkOutput("rst_last",  32'(id_last),  32'd0);
    checkOutput("rst_none",  32'(id_none),  32'd0);
    checkOutput("rst_full",  32'(full),     32'd0);
    checkOutput("rst_drop",  32'(drop_cnt), 32'd0);

    rst      = 1'b0;
    id_ready = 1'b1;
    tick();
    checkQuiet("idle");

    $display("[TB] ids 3, 64, 127 from lane 2");
    in_vec[0] = 128'h200;
    v = '0;
    v[3] = 1'b1; v[64] = 1'b1; v[127] = 1'b1;
    applyStimulus(2, v);
    checkQuiet("t1_lat0");
    tick();
    checkQuiet("t1_lat1");
    tick();
    checkBeat("t1_b3", 3, 1'b0, 1'b0);
    tick();
    checkBeat("t1_b64", 64, 1'b0, 1'b0);
    tick();
    checkBeat("t1_b127", 127, 1'b1, 1'b0);
    tick();
    checkQuiet("t1_done");

    $display("[TB] all-zero vector");
    applyStimulus(1, '0);
    tick();
    tick();
    checkBeat("t2_zero", 0, 1'b1, 1'b1);
    tick();
    checkQuiet("t2_done");

    $display("[TB] stall mid-vector");
    v = '0;
    v[5] = 1'b1; v[9] = 1'b1; v[20] = 1'b1;
    applyStimulus(0, v);
    tick();
    tick();
    checkBeat("t3_b5", 5, 1'b0, 1'b0);
    tick();
    checkBeat("t3_b9", 9, 1'b0, 1'b0);
    id_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checkBeat("t3_stall", 9, 1'b0, 1'b0);
    end
    id_ready = 1'b1;
    tick();
    checkBeat("t3_b20", 20, 1'b1, 1'b0);
    tick();
    checkQuiet("t3_done");

    $display("[TB] four pushes while stalled");
    id_ready = 1'b0;
    lane_sel = 2'd3;
    for (int k = 0; k < 4; k++) begin
      in_vec[3]   = 128'd1 << (k + 1);
      valid_in[3] = 1'b1;
      tick();
      checkOutput("t4_full", 32'(full), (k >= 1) ? 32'd1 : 32'd0);
    end
    valid_in[3] = 1'b0;
    checkOutput("t4_drop", 32'(drop_cnt), 32'(EXP_DROP));
    checkBeat("t4_a", 1, 1'b1, 1'b0);
    id_ready = 1'b1;
    tick();
    checkQuiet("t4_load");
    tick();
    checkBeat("t4_b", 2, 1'b1, 1'b0);
    tick();
    checkQuiet("t4_done");
    checkOutput("t4_empty", 32'(full), 32'd0);

    $display("[TB] reset during scan");
    applyStimulus(0, 128'h000F_FC00);
    tick();
    tick();
    checkBeat("t5_b10", 10, 1'b0, 1'b0);
    tick();
    checkBeat("t5_b11", 11, 1'b0, 1'b0);
    rst         = 1'b1;
    lane_sel    = 2'd3;
    in_vec[3]   = 128'd1 << 99;
    valid_in[3] = 1'b1;
    tick();
    checkQuiet("t5_rst");
    checkOutput("t5_rst_full", 32'(full),     32'd0);
    checkOutput("t5_rst_drop", 32'(drop_cnt), 32'd0);
    rst         = 1'b0;
    valid_in[3] = 1'b0;
    tick();
    checkQuiet("t5_post1");
    tick();
    checkQuiet("t5_post2");
    checkOutput("t5_post_full", 32'(full), 32'd0);
    applyStimulus(0, 128'h80);
    tick();
    tick();
    checkBeat("t5_b7", 7, 1'b1, 1'b0);
    tick();
    checkQuiet("t5_done");

    $display("[TB] push while full on last beat");
    id_ready = 1'b0;
    applyStimulus(1, 128'd1 << 30);
    applyStimulus(2, 128'd1 << 40);
    checkOutput("t6_full", 32'(full), 32'd1);
    tick();
    checkBeat("t6_a", 30, 1'b1, 1'b0);
    id_ready    = 1'b1;
    lane_sel    = 2'd0;
    in_vec[0]   = 128'd1 << 50;
    valid_in[0] = 1'b1;
    tick();
    valid_in[0] = 1'b0;
    checkOutput("t6_still_full", 32'(full),     32'd1);
    checkOutput("t6_no_drop",    32'(drop_cnt), 32'd0);
    checkQuiet("t6_load1");
    tick();
    checkBeat("t6_b", 40, 1'b1, 1'b0);
    tick();
    checkQuiet("t6_load2");
    tick();
    checkBeat("t6_c", 50, 1'b1, 1'b0);
    tick();
    checkQuiet("t6_done");
    checkOutput("t6_empty", 32'(full), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
